timing_control_unit: RTL and testbench
======================================

Name: timing_control_unit

Overview:
Parametrised successor to the basic-computer control unit. It combines the sequence counter, the opcode decoder, the indirect (I) flip-flop and the control-gate logic into one registered FSM. It drives one-hot timing signals, decoded-opcode signals and datapath strobes for fetch, decode, indirect and execute. It adds run/halt control, a datapath-driven end of execute, and sticky sequence-counter overflow detection.

Parameters:
DATA_W, 16, instruction word width; bit DATA_W-1 is the I bit.
OPC_W, 3, opcode field width, ir_data[DATA_W-2 -: OPC_W].
SC_W, 3, sequence counter width; timing signals T0..T(2**SC_W-1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  sets the run flag; single-cycle pulse.
exec_done  in  1  datapath flag: current execute cycle is the last one.
ir_data  in  DATA_W  instruction register contents.
t_out  out  2**SC_W  one-hot timing signals, gated by running.
d_out  out  2**OPC_W  one-hot decoded opcode, registered.
i_flag  out  1  I flip-flop.
running  out  1  run flag (S flip-flop).
phase  out  2  0 FETCH, 1 DECODE, 2 INDIRECT, 3 EXECUTE.
bus_sel  out  3  common-bus source select.
ar_ld  out  1  load AR.
ir_ld  out  1  load IR.
pc_inr  out  1  increment PC.
sc_overflow  out  1  sticky counter-wrap error.

Behaviour:
- All state changes occur on the rising edge of clk. rst_n low clears state immediately, independent of clk.
- Reset values:
  - SC=0, running=0, t_out=0, d_out=0, i_flag=0.
  - phase=FETCH, bus_sel=0, ar_ld=ir_ld=pc_inr=0, sc_overflow=0.
  - The internal halt bit is cleared.
- Idle (running=0):
  - SC held at 0; all strobes 0; t_out=0; bus_sel=0.
  - start=1 sets running=1 at the next edge; the first cycle after that is T0.
- Running: t_out = onehot(SC). SC increments every edge unless cleared.
- Strobes are combinational from SC, phase and registered state:
  - T0, FETCH: bus_sel=2 (PC), ar_ld=1.
  - T1, FETCH: bus_sel=7 (memory), ir_ld=1, pc_inr=1.
  - T2, DECODE: bus_sel=5 (IR), ar_ld=1.
    - At the end of T2, register d_out = onehot(opcode) and i_flag = ir_data[DATA_W-1].
    - Also register halt bit = (opcode all-ones) & ~ir_data[DATA_W-1] & ir_data[0].
  - T3:
    - If d_out[top]=0 and i_flag=1: INDIRECT, bus_sel=7, ar_ld=1. EXECUTE starts at T4.
    - Otherwise EXECUTE starts at T3. In EXECUTE, bus_sel=0 and the strobes are 0; the datapath decodes from t_out, d_out and i_flag.
- ir_data is sampled only at the end of T2. Changes at any other time have no effect.
- Halt: if the halt bit is set, then at the end of T3 running clears and SC clears. exec_done is ignored for that instruction.
- exec_done=1 in EXECUTE: SC clears to 0 at the next edge; phase returns to FETCH. exec_done outside EXECUTE is ignored.
- Overflow: SC at 2**SC_W-1 in EXECUTE with exec_done=0:
  - SC wraps to 0 and phase goes to FETCH.
  - sc_overflow sets and stays set until reset.
- start while running is ignored. start and halt in the same cycle: halt wins.
- d_out and i_flag hold their values until the next T2 capture.
- Reset mid-instruction aborts everything; the next start fetches from T0.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-cycle with no clock edge.
  - Required: all outputs 0 immediately.
  - Stimulus: release reset, hold start=0 for 5 cycles.
  - Required: t_out=0, running=0.
- Direct MRI (defaults):
  - Stimulus: start, ir_data=0x2123, exec_done at T4.
  - Required: t_out=0x01,0x02,0x04,0x08,0x10 then 0x01; d_out=0x04 after T2; i_flag=0.
  - Required: ar_ld at T0 and T2; ir_ld and pc_inr at T1; phase=EXECUTE at T3 and T4.
- Indirect:
  - Stimulus: ir_data=0x9123.
  - Required: d_out=0x02, i_flag=1; at T3 phase=INDIRECT, bus_sel=7, ar_ld=1; EXECUTE from T4.
- Halt:
  - Stimulus: ir_data=0x7001.
  - Required: d_out=0x80; running falls after T3; t_out=0 afterwards.
  - Stimulus: a further start.
  - Required: resumes at T0.
- Overflow:
  - Stimulus: ir_data=0x1000, exec_done never asserted.
  - Required: after T7, SC wraps to T0; sc_overflow=1 and remains set through later instructions.
- Mid-operation:
  - Stimulus: pulse rst_n low at T3 of an instruction.
  - Required: all outputs clear asynchronously.
  - Stimulus: change ir_data at T3.
  - Required: d_out and i_flag do not change.

Source files
------------

// File: rtl/timing_control_unit.sv
// timing_control_unit: sequence counter, opcode decoder, I flip-flop and control gates of the basic computer
// folded into one registered FSM with run/halt control and sticky counter-overflow detection.
module timing_control_unit #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 3,
  parameter int SC_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 exec_done,
  input  logic [DATA_W-1:0]    ir_data,
  output logic [2**SC_W-1:0]   t_out,
  output logic [2**OPC_W-1:0]  d_out,
  output logic                 i_flag,
  output logic                 running,
  output logic [1:0]           phase,
  output logic [2:0]           bus_sel,
  output logic                 ar_ld,
  output logic                 ir_ld,
  output logic                 pc_inr,
  output logic                 sc_overflow
);
  localparam int TW = 2**SC_W;
  localparam int DW = 2**OPC_W;
  localparam logic [SC_W-1:0] SC_MAX = '1;
  typedef enum logic [1:0] {FETCH, DECODE, INDIRECT, EXECUTE} phase_e;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [DW-1:0] d_q, d_d;
  logic run_q, run_d, i_q, i_d, halt_q, halt_d, ovf_q, ovf_d;
  logic [OPC_W-1:0] opc;
  logic t2, t3, ex, halt_now;
  phase_e ph;
  assign opc = ir_data[DATA_W-2 -: OPC_W];
  assign t2 = run_q && sc_q == SC_W'(2);
  assign t3 = run_q && sc_q == SC_W'(3);
  assign halt_now = t3 && halt_q;
  always_comb begin
    ph = FETCH;
    if (run_q)
      ph = sc_q < SC_W'(2) ? FETCH :
           sc_q == SC_W'(2) ? DECODE :
           (sc_q == SC_W'(3) && !d_q[DW-1] && i_q) ? INDIRECT : EXECUTE;
  end
  assign ex = ph == EXECUTE;
  always_comb begin
    ar_ld   = run_q && (sc_q == SC_W'(0) || sc_q == SC_W'(2) || ph == INDIRECT);
    ir_ld   = run_q && sc_q == SC_W'(1);
    pc_inr  = ir_ld;
    bus_sel = !run_q ? 3'd0 :
              sc_q == SC_W'(0) ? 3'd2 :
              sc_q == SC_W'(1) ? 3'd7 :
              sc_q == SC_W'(2) ? 3'd5 :
              ph == INDIRECT ? 3'd7 : 3'd0;
  end
  // Halt takes effect at the end of T3 and overrides exec_done for that instruction.
  always_comb begin
    run_d  = run_q ? !halt_now : start;
    sc_d   = (!run_q || halt_now || (ex && exec_done)) ? '0 : sc_q + SC_W'(1);
    ovf_d  = ovf_q | (ex && !exec_done && !halt_now && sc_q == SC_MAX);
    d_d    = t2 ? DW'(1) << opc : d_q;
    i_d    = t2 ? ir_data[DATA_W-1] : i_q;
    halt_d = t2 ? (&opc & ~ir_data[DATA_W-1] & ir_data[0]) : halt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q   <= '0;
      run_q  <= 1'b0;
      d_q    <= '0;
      i_q    <= 1'b0;
      halt_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      run_q  <= run_d;
      d_q    <= d_d;
      i_q    <= i_d;
      halt_q <= halt_d;
      ovf_q  <= ovf_d;
    end
  end
  assign t_out       = run_q ? TW'(1) << sc_q : '0;
  assign d_out       = d_q;
  assign i_flag      = i_q;
  assign running     = run_q;
  assign phase       = ph;
  assign sc_overflow = ovf_q;
endmodule

// File: tb/tb_timing_control_unit.sv
// tb_timing_control_unit: directed vectors for the timing control unit with hand-computed expectations.
module tb_timing_control_unit;
  logic clk = 1'b0;
  logic rst_n, start, exec_done;
  logic [15:0] ir_data;
  logic [7:0] t_out, d_out;
  logic i_flag, running, ar_ld, ir_ld, pc_inr, sc_overflow;
  logic [1:0] phase;
  logic [2:0] bus_sel;
  int checks = 0;
  int errors = 0;
  timing_control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exec_done(exec_done), .ir_data(ir_data),
    .t_out(t_out), .d_out(d_out), .i_flag(i_flag), .running(running), .phase(phase),
    .bus_sel(bus_sel), .ar_ld(ar_ld), .ir_ld(ir_ld), .pc_inr(pc_inr), .sc_overflow(sc_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Checks timing and strobes {phase,bus_sel,ar_ld,ir_ld,pc_inr} at the sample point, then advances one cycle.
  task automatic step(input string tag, input logic [7:0] t_e, input logic [7:0] s_e);
    chk({tag, "_t"}, t_out, t_e);
    chk({tag, "_s"}, {phase, bus_sel, ar_ld, ir_ld, pc_inr}, s_e);
    @(negedge clk);
  endtask
  task automatic all_zero(input string tag);
    chk(tag, {t_out, d_out, i_flag, running, phase, bus_sel, ar_ld, ir_ld, pc_inr, sc_overflow}, 0);
  endtask
  task automatic pulse_start(input logic [15:0] ir);
    ir_data = ir;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b1; start = 1'b0; exec_done = 1'b0; ir_data = 16'h0000;
    #3 rst_n = 1'b0;
    #1 all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_t", t_out, 8'h00);
      chk("idle_run", running, 1'b0);
    end
    pulse_start(16'h2123);
    chk("mri_run", running, 1'b1);
    step("mri_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("mri_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("mri_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    chk("mri_d", d_out, 8'h04);
    chk("mri_i", i_flag, 1'b0);
    step("mri_T3", 8'h08, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b1;
    step("mri_T4", 8'h10, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b0;
    ir_data = 16'h9123;
    step("ind_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("ind_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("ind_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    chk("ind_d", d_out, 8'h02);
    chk("ind_i", i_flag, 1'b1);
    step("ind_T3", 8'h08, {2'd2, 3'd7, 3'b100});
    exec_done = 1'b1;
    step("ind_T4", 8'h10, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b0;
    ir_data = 16'h7001;
    step("hlt_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("hlt_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("hlt_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    chk("hlt_d", d_out, 8'h80);
    chk("hlt_run3", running, 1'b1);
    exec_done = 1'b1;
    step("hlt_T3", 8'h08, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b0;
    chk("hlt_run", running, 1'b0);
    step("hlt_idle0", 8'h00, 8'h00);
    step("hlt_idle1", 8'h00, 8'h00);
    pulse_start(16'h1000);
    chk("res_run", running, 1'b1);
    step("ovf_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("ovf_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("ovf_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    chk("ovf_d", d_out, 8'h02);
    step("ovf_T3", 8'h08, {2'd3, 3'd0, 3'b000});
    step("ovf_T4", 8'h10, {2'd3, 3'd0, 3'b000});
    step("ovf_T5", 8'h20, {2'd3, 3'd0, 3'b000});
    step("ovf_T6", 8'h40, {2'd3, 3'd0, 3'b000});
    chk("ovf_pre", sc_overflow, 1'b0);
    step("ovf_T7", 8'h80, {2'd3, 3'd0, 3'b000});
    chk("ovf_set", sc_overflow, 1'b1);
    step("wrap_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("wrap_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("wrap_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    exec_done = 1'b1;
    step("wrap_T3", 8'h08, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b0;
    chk("ovf_sticky", sc_overflow, 1'b1);
    step("irc_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("irc_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("irc_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    ir_data = 16'h9123;
    step("irc_T3", 8'h08, {2'd3, 3'd0, 3'b000});
    chk("irc_d", d_out, 8'h02);
    chk("irc_i", i_flag, 1'b0);
    exec_done = 1'b1;
    step("irc_T4", 8'h10, {2'd3, 3'd0, 3'b000});
    exec_done = 1'b0;
    chk("irc_ovf", sc_overflow, 1'b1);
    step("mid_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    step("mid_T1", 8'h02, {2'd0, 3'd7, 3'b011});
    step("mid_T2", 8'h04, {2'd1, 3'd5, 3'b100});
    chk("mid_T3_s", {phase, bus_sel, ar_ld, ir_ld, pc_inr}, {2'd2, 3'd7, 3'b100});
    #2 rst_n = 1'b0;
    #1 all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    all_zero("post_rst_idle");
    pulse_start(16'h2123);
    step("post_T0", 8'h01, {2'd0, 3'd2, 3'b100});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
